// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the pipelined Wishbone memory slave.
// resp_t is the default-width response entry; the top builds a DATA_W-sized twin.
package wb_mem_pkg;

    localparam int DEF_DATA_W = 32;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DEF_DATA_W-1:0] data;
    } resp_t;

    function automatic logic [7:0] lane_bits(input logic sel);
        return {8{sel}};
    endfunction

    function automatic logic in_range(input logic [63:0] byte_addr,
                                      input logic [63:0] depth_bytes);
        return byte_addr < depth_bytes;
    endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response shift register; flush drops every in-flight entry
// on the edge it is sampled high (used for Wishbone cycle abort).
module wb_resp_pipe
    import wb_mem_pkg::*;
#(
    parameter int  STAGES  = 1,
    parameter type entry_t = resp_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout
);

    entry_t stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            // Data may linger after a flush; only valid matters downstream.
            if (flush) begin
                for (int i = 0; i < STAGES; i++) stage[i].valid <= 1'b0;
            end
        end
    end

    assign dout = stage[STAGES-1];

endmodule

// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone B4 memory slave with READ_LAT-cycle responses.
// Define WB_PIPE_MEM_STALL_INJECT_EN to enable LFSR-driven stall injection.
module wb_pipe_mem
    import wb_mem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_BYTES = 65536,
    parameter int          ADDR_W      = 32,
    parameter int          READ_LAT    = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         GRAN        = $clog2(DATA_W / 8)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cyc_i,
    input  logic                   stb_i,
    input  logic                   we_i,
    input  logic [ADDR_W-GRAN-1:0] addr_i,
    input  logic [DATA_W/8-1:0]    sel_i,
    input  logic [DATA_W-1:0]      dat_i,
    output logic                   ack_o,
    output logic                   err_o,
    output logic                   stall_o,
    output logic [DATA_W-1:0]      dat_o
);

    localparam int LANES = DATA_W / 8;
    localparam int WORDS = DEPTH_BYTES / LANES;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("wb_pipe_mem: READ_LAT must be in 1..4");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("wb_pipe_mem: LFSR_SEED of zero locks the LFSR");
    end

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] mem [WORDS];
    logic [ADDR_W-1:0] byte_addr;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              accept;
    logic [DATA_W-1:0] mask;
    entry_t            req;
    entry_t            resp;

    // Upper address bits take part in the compare so aliases are rejected.
    assign byte_addr = ADDR_W'(addr_i) << GRAN;
    assign idx       = addr_i[IDX_W-1:0];
    assign hit       = in_range(64'(byte_addr), 64'(DEPTH_BYTES));
    assign accept    = cyc_i & stb_i & ~stall_o;

    always_comb begin
        mask = '0;
        for (int l = 0; l < LANES; l++) mask[l*8 +: 8] = lane_bits(sel_i[l]);
    end

    // Writes commit at acceptance, so later reads never need forwarding.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && hit) begin
            mem[idx] <= (mem[idx] & ~mask) | (dat_i & mask);
        end
    end

    always_comb begin
        req       = '0;
        req.valid = accept;
        req.err   = ~hit;
        req.data  = (accept && hit) ? mem[idx] : '0;
    end

    wb_resp_pipe #(
        .STAGES  (READ_LAT),
        .entry_t (entry_t)
    ) u_resp_pipe (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (~cyc_i),
        .din   (req),
        .dout  (resp)
    );

    assign ack_o = resp.valid & ~resp.err;
    assign err_o = resp.valid & resp.err;
    assign dat_o = resp.data;

`ifdef WB_PIPE_MEM_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
        end
    end

    assign stall_o = lfsr[0] & lfsr[1];
`else
    assign stall_o = 1'b0;
`endif

endmodule
